ssd_scan_ctrl: RTL

- Time-multiplexes NUM_DIGITS packed BCD digits onto a single shared BCD-to-seven-segment decoder and its common segment bus.
- Each cycle it drives the decoder's 4-bit BCD input and chip-select, plus a one-hot digit-enable vector for the display commons.
- A double-buffered load handshake changes display content only at frame boundaries, so a digit is never torn mid-frame.

---
 rtl/ssd_scan_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: scans NUM_DIGITS packed BCD digits onto one shared
// BCD-to-seven-segment decoder, with one-hot digit enables, per-slot
// anti-ghosting blanking, leading-zero suppression and a double-buffered
// load path that only swaps display content at frame boundaries.
module ssd_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000,
  parameter int BLANK_CYC  = 2,
  parameter bit LZ_BLANK   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  output logic                    load_ack,
  output logic [3:0]              bcd_out,
  output logic                    cs_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick,
  output logic                    err_bcd
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] BLANK_V = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_SCAN = 1'b1} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_active;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic                    r_pending;
  logic                    r_load_ack;
  logic                    r_frame_tick;
  logic                    r_err;

  logic [3:0]              w_nib;
  logic                    w_upper_zero;
  logic                    w_blank;
  logic                    w_lit;
  logic                    w_boundary;
  logic                    w_direct;
  logic                    w_promote;

  // Last cycle of the last slot closes a frame; display swaps happen here.
  assign w_boundary = (r_state == ST_SCAN) && (r_cnt == CNT_MAX) && (r_idx == IDX_MAX);
  // A load goes straight to the active buffer when nothing can be torn by it.
  assign w_direct   = load && (w_boundary || ((r_state == ST_IDLE) && !r_pending));
  // A parked load is promoted at a boundary, or immediately while the display is idle.
  assign w_promote  = !load && r_pending && (w_boundary || (r_state == ST_IDLE));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: en alone starts or aborts scanning, even mid-slot.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (en)  w_state_nxt = ST_SCAN;
      ST_SCAN: if (!en) w_state_nxt = ST_IDLE;
      default:          w_state_nxt = ST_IDLE;
    endcase
  end

  // Slot counter and digit index; both restart from zero whenever scanning stops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if ((r_state == ST_SCAN) && en) begin
      if (r_cnt == CNT_MAX) begin
        r_cnt <= '0;
        r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_cnt <= '0;
      r_idx <= '0;
    end
  end

  // Select the current nibble and decide whether it is a leading zero.
  always_comb begin
    w_nib        = 4'd0;
    w_upper_zero = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) w_nib = r_active[4*k +: 4];
      if ((IDX_W'(k) >= r_idx) && (r_active[4*k +: 4] != 4'd0)) w_upper_zero = 1'b0;
    end
    w_blank = LZ_BLANK && (r_idx != '0) && w_upper_zero;
  end

  // Output decode: digit enable after the blanking window, chip-select only for valid shown digits.
  always_comb begin
    an    = '0;
    w_lit = 1'b0;
    if ((r_state == ST_SCAN) && (r_cnt >= BLANK_V)) begin
      w_lit = 1'b1;
      for (int k = 0; k < NUM_DIGITS; k++) an[k] = (r_idx == IDX_W'(k));
    end
    cs_out = w_lit && !w_blank && (w_nib <= 4'd9);
  end

  assign bcd_out = w_nib;

  // Double-buffered display content with a one-cycle acknowledge on activation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active   <= '0;
      r_shadow   <= '0;
      r_pending  <= 1'b0;
      r_load_ack <= 1'b0;
    end else begin
      r_load_ack <= w_direct || w_promote;
      if (w_direct) begin
        r_active  <= digits_in;
        r_pending <= 1'b0;
      end else if (load) begin
        r_shadow  <= digits_in;
        r_pending <= 1'b1;
      end else if (w_promote) begin
        r_active  <= r_shadow;
        r_pending <= 1'b0;
      end
    end
  end

  // Frame tick and sticky invalid-digit flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_tick <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_frame_tick <= w_boundary;
      if (w_lit && (w_nib > 4'd9)) r_err <= 1'b1;
    end
  end

  assign load_ack   = r_load_ack;
  assign frame_tick = r_frame_tick;
  assign err_bcd    = r_err;

endmodule
